// File: rtl/clock_pkg.sv
// Shared definitions for the world-clock user interface: display state codes,
// timezone code range and edit-field indices.
package clock_pkg;

  typedef enum logic [3:0] {
    ST_NORMAL   = 4'b1000,
    ST_SETUP    = 4'b0100,
    ST_TIME_SET = 4'b0101,
    ST_TZ_SET   = 4'b0110
  } state_e;

  // Timezone codes run 0..13; code 9 is KST.
  localparam logic [4:0] TZ_COUNT = 5'd14;
  localparam logic [4:0] TZ_MIN   = 5'd0;
  localparam logic [4:0] TZ_MAX   = 5'd13;
  localparam logic [4:0] TZ_KST   = 5'd9;

  localparam logic [1:0] FIELD_HOUR = 2'd0;
  localparam logic [1:0] FIELD_MIN  = 2'd1;
  localparam logic [1:0] FIELD_SEC  = 2'd2;

  localparam logic [5:0] HOUR_MOD   = 6'd24;
  localparam logic [5:0] MINSEC_MOD = 6'd60;

endpackage

// File: rtl/field_step.sv
// Combinational modular up/down stepper shared by the time fields and the
// timezone selector. Values already outside the range are stepped as if 0.
module field_step #(
  parameter int W = 6
) (
  input  logic [W-1:0] value_i,
  input  logic [W-1:0] modulus_i,
  input  logic         up_i,
  input  logic         down_i,
  output logic [W-1:0] next_o
);

  logic [W-1:0] base;

  always_comb begin
    base   = (value_i >= modulus_i) ? '0 : value_i;
    next_o = value_i;
    if (up_i) begin
      next_o = (base == modulus_i - W'(1)) ? '0 : base + W'(1);
    end else if (down_i) begin
      next_o = (base == '0) ? modulus_i - W'(1) : base - W'(1);
    end
  end

endmodule

// File: rtl/clock_setup_ctrl.sv
// Button-driven setup sequencer for the world clock: edits the UTC set buffer,
// selects the timezone and strobes TIME_LOAD on a time commit.
module clock_setup_ctrl
  import clock_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000,
  parameter logic [4:0]  TZ_DEFAULT     = 5'b01001
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        BTN_MENU,
  input  logic        BTN_OK,
  input  logic        BTN_NEXT,
  input  logic        BTN_UP,
  input  logic        BTN_DOWN,
  input  logic [17:0] CLOCK_DATA,
  output logic [3:0]  STATE,
  output logic [17:0] TIME_SETDATA,
  output logic [4:0]  TZ_DATA,
  output logic        TIME_LOAD,
  output logic [1:0]  FIELD_SEL,
  output logic        MENU_SEL
);

  state_e      state_q, state_d;
  logic [17:0] time_q, time_d;
  logic [1:0]  field_q, field_d;
  logic        menuSel_q, menuSel_d;
  logic [4:0]  tz_q, tz_d;
  logic [4:0]  tzCommit_q, tzCommit_d;
  logic        load_q, load_d;
  logic [31:0] idle_q, idle_d;

  logic btnMenu, btnOk, btnNext, btnUp, btnDown, anyBtn, timeout;
  logic [5:0] fieldVal, fieldMod, fieldNext;
  logic [4:0] tzNext;

  // Only the highest-priority button of a simultaneous group is acted on.
  assign btnMenu = BTN_MENU;
  assign btnOk   = BTN_OK   & ~btnMenu;
  assign btnNext = BTN_NEXT & ~btnMenu & ~btnOk;
  assign btnUp   = BTN_UP   & ~btnMenu & ~btnOk & ~btnNext;
  assign btnDown = BTN_DOWN & ~btnMenu & ~btnOk & ~btnNext & ~btnUp;
  assign anyBtn  = BTN_MENU | BTN_OK | BTN_NEXT | BTN_UP | BTN_DOWN;
  assign timeout = (state_q != ST_NORMAL) && !anyBtn && (idle_q == TIMEOUT_CYCLES - 32'd1);

  always_comb begin
    fieldVal = time_q[5:0];
    fieldMod = MINSEC_MOD;
    case (field_q)
      FIELD_HOUR: begin
        fieldVal = time_q[17:12];
        fieldMod = HOUR_MOD;
      end
      FIELD_MIN: fieldVal = time_q[11:6];
      default:   fieldVal = time_q[5:0];
    endcase
  end

  field_step #(.W(6)) u_time_step (
    .value_i  (fieldVal),
    .modulus_i(fieldMod),
    .up_i     (btnUp),
    .down_i   (btnDown),
    .next_o   (fieldNext)
  );

  field_step #(.W(5)) u_tz_step (
    .value_i  (tz_q),
    .modulus_i(TZ_COUNT),
    .up_i     (btnUp),
    .down_i   (btnDown),
    .next_o   (tzNext)
  );

  always_comb begin
    state_d    = state_q;
    time_d     = time_q;
    field_d    = field_q;
    menuSel_d  = menuSel_q;
    tz_d       = tz_q;
    tzCommit_d = tzCommit_q;
    load_d     = 1'b0;
    idle_d     = (anyBtn || state_q == ST_NORMAL) ? 32'd0 : idle_q + 32'd1;

    case (state_q)
      ST_NORMAL: begin
        if (btnMenu) begin
          state_d   = ST_SETUP;
          menuSel_d = 1'b0;
        end
      end
      ST_SETUP: begin
        if (btnMenu) begin
          state_d = ST_NORMAL;
        end else if (btnOk) begin
          if (menuSel_q) begin
            state_d = ST_TZ_SET;
            tz_d    = tzCommit_q;
          end else begin
            state_d = ST_TIME_SET;
            time_d  = CLOCK_DATA;
            field_d = FIELD_HOUR;
          end
        end else if (btnUp || btnDown) begin
          menuSel_d = ~menuSel_q;
        end
      end
      ST_TIME_SET: begin
        if (btnMenu) begin
          state_d = ST_NORMAL;
        end else if (btnOk) begin
          state_d = ST_NORMAL;
          load_d  = 1'b1;
        end else if (btnNext) begin
          field_d = (field_q == FIELD_SEC) ? FIELD_HOUR : field_q + 2'd1;
        end else if (btnUp || btnDown) begin
          case (field_q)
            FIELD_HOUR: time_d[17:12] = fieldNext;
            FIELD_MIN:  time_d[11:6]  = fieldNext;
            default:    time_d[5:0]   = fieldNext;
          endcase
        end
      end
      ST_TZ_SET: begin
        if (btnMenu) begin
          state_d = ST_NORMAL;
          tz_d    = tzCommit_q;
        end else if (btnOk) begin
          state_d    = ST_NORMAL;
          tzCommit_d = tz_q;
        end else if (btnUp || btnDown) begin
          tz_d = tzNext;
        end
      end
      default: state_d = ST_NORMAL;
    endcase

    // An idle expiry behaves exactly like a MENU cancel.
    if (timeout) begin
      state_d = ST_NORMAL;
      tz_d    = tzCommit_q;
      idle_d  = 32'd0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_NORMAL;
      time_q     <= 18'd0;
      field_q    <= FIELD_HOUR;
      menuSel_q  <= 1'b0;
      tz_q       <= TZ_DEFAULT;
      tzCommit_q <= TZ_DEFAULT;
      load_q     <= 1'b0;
      idle_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      time_q     <= time_d;
      field_q    <= field_d;
      menuSel_q  <= menuSel_d;
      tz_q       <= tz_d;
      tzCommit_q <= tzCommit_d;
      load_q     <= load_d;
      idle_q     <= idle_d;
    end
  end

  assign STATE        = state_q;
  assign TIME_SETDATA = time_q;
  assign TZ_DATA      = tz_q;
  assign TIME_LOAD    = load_q;
  assign FIELD_SEL    = field_q;
  assign MENU_SEL     = menuSel_q;

endmodule

// File: tb/tb_clock_setup_ctrl.sv
// Directed bench for clock_setup_ctrl: reset, time commit, wrapping,
// timezone cancel, button priority and idle timeout.
module tb_clock_setup_ctrl;

  localparam logic [3:0] S_NORMAL   = 4'b1000;
  localparam logic [3:0] S_SETUP    = 4'b0100;
  localparam logic [3:0] S_TIME_SET = 4'b0101;
  localparam logic [3:0] S_TZ_SET   = 4'b0110;

  localparam logic [4:0] B_MENU = 5'b10000;
  localparam logic [4:0] B_OK   = 5'b01000;
  localparam logic [4:0] B_NEXT = 5'b00100;
  localparam logic [4:0] B_UP   = 5'b00010;
  localparam logic [4:0] B_DOWN = 5'b00001;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        BTN_MENU = 1'b0, BTN_OK = 1'b0, BTN_NEXT = 1'b0, BTN_UP = 1'b0, BTN_DOWN = 1'b0;
  logic [17:0] CLOCK_DATA = 18'd0;
  logic [3:0]  STATE;
  logic [17:0] TIME_SETDATA;
  logic [4:0]  TZ_DATA;
  logic        TIME_LOAD;
  logic [1:0]  FIELD_SEL;
  logic        MENU_SEL;

  int testsRun = 0;
  int testsFailed = 0;
  int loadCount = 0;
  int loadBase;

  clock_setup_ctrl #(.TIMEOUT_CYCLES(32'd16), .TZ_DEFAULT(5'b01001)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .BTN_MENU    (BTN_MENU),
    .BTN_OK      (BTN_OK),
    .BTN_NEXT    (BTN_NEXT),
    .BTN_UP      (BTN_UP),
    .BTN_DOWN    (BTN_DOWN),
    .CLOCK_DATA  (CLOCK_DATA),
    .STATE       (STATE),
    .TIME_SETDATA(TIME_SETDATA),
    .TZ_DATA     (TZ_DATA),
    .TIME_LOAD   (TIME_LOAD),
    .FIELD_SEL   (FIELD_SEL),
    .MENU_SEL    (MENU_SEL)
  );

  always #5 CLK = ~CLK;

  // Every cycle with the load strobe high is counted once.
  always @(posedge CLK) begin
    #1;
    if (TIME_LOAD === 1'b1) loadCount++;
  end

  function automatic logic [17:0] hms(input int h, input int m, input int s);
    return {h[5:0], m[5:0], s[5:0]};
  endfunction

  // Called at a falling edge; holds the buttons for one rising edge.
  task automatic pulse(input logic [4:0] b);
    {BTN_MENU, BTN_OK, BTN_NEXT, BTN_UP, BTN_DOWN} = b;
    @(negedge CLK);
    {BTN_MENU, BTN_OK, BTN_NEXT, BTN_UP, BTN_DOWN} = 5'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    testsRun++; if (STATE !== S_NORMAL) begin testsFailed++; $display("[TB] FAIL reset_state got %b want %b", STATE, S_NORMAL); end
    testsRun++; if (TIME_SETDATA !== 18'd0) begin testsFailed++; $display("[TB] FAIL reset_setdata got %h want 0", TIME_SETDATA); end
    testsRun++; if (TZ_DATA !== 5'b01001) begin testsFailed++; $display("[TB] FAIL reset_tz got %b want 01001", TZ_DATA); end
    testsRun++; if (TIME_LOAD !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_load got %b want 0", TIME_LOAD); end
    testsRun++; if (FIELD_SEL !== 2'd0) begin testsFailed++; $display("[TB] FAIL reset_field got %0d want 0", FIELD_SEL); end
    testsRun++; if (MENU_SEL !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_menusel got %b want 0", MENU_SEL); end
    CLOCK_DATA = hms(5, 6, 7);
    pulse(B_MENU); pulse(B_OK); pulse(B_UP);
    testsRun++; if (TIME_SETDATA !== hms(6, 6, 7)) begin testsFailed++; $display("[TB] FAIL midedit_setdata got %h want %h", TIME_SETDATA, hms(6, 6, 7)); end
    loadBase = loadCount;
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    testsRun++; if (STATE !== S_NORMAL) begin testsFailed++; $display("[TB] FAIL midreset_state got %b want %b", STATE, S_NORMAL); end
    testsRun++; if (TZ_DATA !== 5'b01001) begin testsFailed++; $display("[TB] FAIL midreset_tz got %b want 01001", TZ_DATA); end
    testsRun++; if (TIME_SETDATA !== 18'd0) begin testsFailed++; $display("[TB] FAIL midreset_setdata got %h want 0", TIME_SETDATA); end
    testsRun++; if (loadCount !== loadBase) begin testsFailed++; $display("[TB] FAIL midreset_noload got %0d loads want %0d", loadCount, loadBase); end
  endtask

  task automatic test_time_commit;
    CLOCK_DATA = hms(12, 34, 56);
    pulse(B_MENU);
    testsRun++; if (STATE !== S_SETUP) begin testsFailed++; $display("[TB] FAIL commit_setup got %b want %b", STATE, S_SETUP); end
    pulse(B_OK);
    testsRun++; if (TIME_SETDATA !== hms(12, 34, 56)) begin testsFailed++; $display("[TB] FAIL commit_capture got %h want %h", TIME_SETDATA, hms(12, 34, 56)); end
    pulse(B_UP); pulse(B_NEXT);
    testsRun++; if (FIELD_SEL !== 2'd1) begin testsFailed++; $display("[TB] FAIL commit_field got %0d want 1", FIELD_SEL); end
    pulse(B_DOWN);
    loadBase = loadCount;
    pulse(B_OK);
    testsRun++; if (TIME_LOAD !== 1'b1) begin testsFailed++; $display("[TB] FAIL commit_load got %b want 1", TIME_LOAD); end
    testsRun++; if (STATE !== S_NORMAL) begin testsFailed++; $display("[TB] FAIL commit_state got %b want %b", STATE, S_NORMAL); end
    testsRun++; if (TIME_SETDATA !== hms(13, 33, 56)) begin testsFailed++; $display("[TB] FAIL commit_data got %h want %h", TIME_SETDATA, hms(13, 33, 56)); end
    idle(3);
    testsRun++; if (loadCount !== loadBase + 1) begin testsFailed++; $display("[TB] FAIL commit_onepulse got %0d loads want %0d", loadCount - loadBase, 1); end
  endtask

  task automatic test_wrap;
    CLOCK_DATA = hms(23, 0, 59);
    pulse(B_MENU); pulse(B_OK); pulse(B_UP);
    testsRun++; if (TIME_SETDATA[17:12] !== 6'd0) begin testsFailed++; $display("[TB] FAIL wrap_hour_up got %0d want 0", TIME_SETDATA[17:12]); end
    pulse(B_DOWN);
    testsRun++; if (TIME_SETDATA[17:12] !== 6'd23) begin testsFailed++; $display("[TB] FAIL wrap_hour_down got %0d want 23", TIME_SETDATA[17:12]); end
    pulse(B_NEXT); pulse(B_NEXT); pulse(B_UP);
    testsRun++; if (TIME_SETDATA !== hms(23, 0, 0)) begin testsFailed++; $display("[TB] FAIL wrap_sec_up got %h want %h", TIME_SETDATA, hms(23, 0, 0)); end
    pulse(B_NEXT);
    testsRun++; if (FIELD_SEL !== 2'd0) begin testsFailed++; $display("[TB] FAIL wrap_field got %0d want 0", FIELD_SEL); end
    pulse(B_MENU);
    CLOCK_DATA = hms(30, 61, 0);
    pulse(B_MENU); pulse(B_OK); pulse(B_UP); pulse(B_NEXT); pulse(B_DOWN);
    testsRun++; if (TIME_SETDATA !== hms(1, 59, 0)) begin testsFailed++; $display("[TB] FAIL wrap_outofrange got %h want %h", TIME_SETDATA, hms(1, 59, 0)); end
    pulse(B_MENU);
    pulse(B_MENU); pulse(B_DOWN);
    testsRun++; if (MENU_SEL !== 1'b1) begin testsFailed++; $display("[TB] FAIL wrap_menusel got %b want 1", MENU_SEL); end
    pulse(B_OK);
    repeat (4) pulse(B_UP);
    testsRun++; if (TZ_DATA !== 5'd13) begin testsFailed++; $display("[TB] FAIL wrap_tz13 got %0d want 13", TZ_DATA); end
    pulse(B_UP);
    testsRun++; if (TZ_DATA !== 5'd0) begin testsFailed++; $display("[TB] FAIL wrap_tz_up got %0d want 0", TZ_DATA); end
    pulse(B_DOWN);
    testsRun++; if (TZ_DATA !== 5'd13) begin testsFailed++; $display("[TB] FAIL wrap_tz_down got %0d want 13", TZ_DATA); end
    repeat (4) pulse(B_DOWN);
    pulse(B_OK);
    testsRun++; if (TZ_DATA !== 5'd9 || STATE !== S_NORMAL) begin testsFailed++; $display("[TB] FAIL wrap_tz_commit got tz %0d state %b want 9 %b", TZ_DATA, STATE, S_NORMAL); end
  endtask

  task automatic test_tz_cancel;
    loadBase = loadCount;
    pulse(B_MENU);
    testsRun++; if (MENU_SEL !== 1'b0) begin testsFailed++; $display("[TB] FAIL tzc_menusel got %b want 0", MENU_SEL); end
    pulse(B_UP); pulse(B_OK);
    testsRun++; if (STATE !== S_TZ_SET) begin testsFailed++; $display("[TB] FAIL tzc_state got %b want %b", STATE, S_TZ_SET); end
    pulse(B_UP);
    testsRun++; if (TZ_DATA !== 5'b01010) begin testsFailed++; $display("[TB] FAIL tzc_prev1 got %b want 01010", TZ_DATA); end
    pulse(B_UP);
    testsRun++; if (TZ_DATA !== 5'b01011) begin testsFailed++; $display("[TB] FAIL tzc_prev2 got %b want 01011", TZ_DATA); end
    pulse(B_MENU);
    testsRun++; if (TZ_DATA !== 5'b01001 || STATE !== S_NORMAL) begin testsFailed++; $display("[TB] FAIL tzc_revert got tz %b state %b want 01001 %b", TZ_DATA, STATE, S_NORMAL); end
    idle(2);
    testsRun++; if (loadCount !== loadBase) begin testsFailed++; $display("[TB] FAIL tzc_noload got %0d loads want 0", loadCount - loadBase); end
  endtask

  task automatic test_priority;
    pulse(B_OK | B_UP);
    testsRun++; if (STATE !== S_NORMAL) begin testsFailed++; $display("[TB] FAIL prio_normal_ignore got %b want %b", STATE, S_NORMAL); end
    CLOCK_DATA = hms(12, 34, 56);
    pulse(B_MENU);
    pulse(B_UP | B_DOWN);
    testsRun++; if (MENU_SEL !== 1'b1) begin testsFailed++; $display("[TB] FAIL prio_single_toggle got %b want 1", MENU_SEL); end
    pulse(B_DOWN); pulse(B_OK);
    loadBase = loadCount;
    pulse(B_OK | B_UP);
    testsRun++; if (TIME_LOAD !== 1'b1 || TIME_SETDATA !== hms(12, 34, 56)) begin testsFailed++; $display("[TB] FAIL prio_ok_up got load %b data %h want 1 %h", TIME_LOAD, TIME_SETDATA, hms(12, 34, 56)); end
    pulse(B_MENU); pulse(B_OK);
    pulse(B_MENU | B_OK);
    testsRun++; if (STATE !== S_NORMAL || TIME_LOAD !== 1'b0) begin testsFailed++; $display("[TB] FAIL prio_menu_ok got state %b load %b want %b 0", STATE, TIME_LOAD, S_NORMAL); end
    idle(2);
    testsRun++; if (loadCount !== loadBase + 1) begin testsFailed++; $display("[TB] FAIL prio_loads got %0d want 1", loadCount - loadBase); end
  endtask

  task automatic test_timeout;
    pulse(B_MENU); pulse(B_UP); pulse(B_OK); pulse(B_UP);
    idle(15);
    testsRun++; if (STATE !== S_TZ_SET || TZ_DATA !== 5'd10) begin testsFailed++; $display("[TB] FAIL tmo_before got state %b tz %0d want %b 10", STATE, TZ_DATA, S_TZ_SET); end
    idle(1);
    testsRun++; if (STATE !== S_NORMAL || TZ_DATA !== 5'd9) begin testsFailed++; $display("[TB] FAIL tmo_expire got state %b tz %0d want %b 9", STATE, TZ_DATA, S_NORMAL); end
    pulse(B_MENU); pulse(B_UP); pulse(B_OK); pulse(B_UP);
    idle(15);
    pulse(B_UP);
    testsRun++; if (STATE !== S_TZ_SET || TZ_DATA !== 5'd11) begin testsFailed++; $display("[TB] FAIL tmo_btn_wins got state %b tz %0d want %b 11", STATE, TZ_DATA, S_TZ_SET); end
    idle(15);
    testsRun++; if (STATE !== S_TZ_SET) begin testsFailed++; $display("[TB] FAIL tmo_restart got %b want %b", STATE, S_TZ_SET); end
    idle(1);
    testsRun++; if (STATE !== S_NORMAL || TZ_DATA !== 5'd9) begin testsFailed++; $display("[TB] FAIL tmo_expire2 got state %b tz %0d want %b 9", STATE, TZ_DATA, S_NORMAL); end
  endtask

  initial begin
    @(negedge CLK);
    test_reset;
    test_time_commit;
    test_wrap;
    test_tz_cancel;
    test_priority;
    test_timeout;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
